// File: rtl/nios_mult_pkg.sv
// nios_mult_pkg: op encoding and result-word selection for nios_mult_pipe.
// Shared by the pipeline top and its bench; no ports.
package nios_mult_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'd0,
    MUL_OP_MULXUU = 2'd1,
    MUL_OP_MULXSU = 2'd2,
    MUL_OP_MULXSS = 2'd3
  } mult_op_e;

  // Widest operand the select helper handles.
  localparam int unsigned MULT_MAX_W = 64;

  // MUL keeps the low word, every MULX* the high word.
  // p is the zero-extended 2*w product; caller truncates to w.
  function automatic logic [MULT_MAX_W-1:0] mult_select(
    input logic [2*MULT_MAX_W-1:0] p,
    input int unsigned             w,
    input mult_op_e                op
  );
    if (op == MUL_OP_MUL)
      return p[MULT_MAX_W-1:0];
    return MULT_MAX_W'(p >> w);
  endfunction

  function automatic logic mult_a_signed(input mult_op_e op);
    return (op == MUL_OP_MULXSU) || (op == MUL_OP_MULXSS);
  endfunction

endpackage

// File: rtl/nios_mult_if.sv
// nios_mult_if: issue/result handshake bundle of nios_mult_pipe.
// Ports: flush, in_* (valid/ready/op/src1/src2/tag), out_* (valid/ready/result/tag).
interface nios_mult_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [DATA_W-1:0] in_src1;
  logic [DATA_W-1:0] in_src2;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output flush, in_valid, in_op,
    output in_src1, in_src2, in_tag,
    output out_ready,
    input  in_ready, out_valid,
    input  out_result, out_tag
  );

  modport slave (
    input  flush, in_valid, in_op,
    input  in_src1, in_src2, in_tag,
    input  out_ready,
    output in_ready, out_valid,
    output out_result, out_tag
  );
endinterface

// File: rtl/nios_mult_pp.sv
// nios_mult_pp: registered unsigned W x W partial product with enable.
// Ports: clk_i, rst_ni (sync low), en_i, a_i, b_i, p_o (2*W, registered).
module nios_mult_pp #(
  parameter int W = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           en_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);
  logic [2*W-1:0] p_q, p_d;

  always_comb begin
    p_d = (2*W)'(a_i) * (2*W)'(b_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      p_q <= '0;
    else if (en_i)
      p_q <= p_d;
  end

  assign p_o = p_q;
endmodule

// File: rtl/nios_mult_pipe.sv
// nios_mult_pipe: pipelined DATA_W multiplier, MUL/MULXUU/MULXSU/MULXSS.
// Ports: clk, reset_n (sync low), bus (nios_mult_if.slave). NIOS_MULT_OUT_REG_EN adds S3.
module nios_mult_pipe
  import nios_mult_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input logic       clk,
  input logic       reset_n,
  nios_mult_if.slave bus
);
  localparam int HALF_W = DATA_W / 2;
  localparam int PW     = 2 * DATA_W;

  logic stall, accept;

  logic [DATA_W-1:0] pll, plh, phl, phh;

  logic              s1_vld_q, s1_vld_d;
  mult_op_e          op1_q;
  logic [TAG_W-1:0]  tag1_q;
  logic [DATA_W-1:0] a1_q, b1_q;

  logic              s2_vld_q, s2_vld_d;
  logic [DATA_W-1:0] res2_q, res2_d;
  logic [TAG_W-1:0]  tag2_q;

  logic [PW-1:0] mid, p_sum;

  assign bus.in_ready = !stall;
  assign accept = bus.in_valid && !stall && !bus.flush;

  nios_mult_pp #(.W(HALF_W)) u_pp_ll (
    .clk_i(clk), .rst_ni(reset_n), .en_i(accept),
    .a_i(bus.in_src1[HALF_W-1:0]),
    .b_i(bus.in_src2[HALF_W-1:0]),
    .p_o(pll)
  );
  nios_mult_pp #(.W(HALF_W)) u_pp_lh (
    .clk_i(clk), .rst_ni(reset_n), .en_i(accept),
    .a_i(bus.in_src1[HALF_W-1:0]),
    .b_i(bus.in_src2[DATA_W-1:HALF_W]),
    .p_o(plh)
  );
  nios_mult_pp #(.W(HALF_W)) u_pp_hl (
    .clk_i(clk), .rst_ni(reset_n), .en_i(accept),
    .a_i(bus.in_src1[DATA_W-1:HALF_W]),
    .b_i(bus.in_src2[HALF_W-1:0]),
    .p_o(phl)
  );
  nios_mult_pp #(.W(HALF_W)) u_pp_hh (
    .clk_i(clk), .rst_ni(reset_n), .en_i(accept),
    .a_i(bus.in_src1[DATA_W-1:HALF_W]),
    .b_i(bus.in_src2[DATA_W-1:HALF_W]),
    .p_o(phh)
  );

  always_comb begin
    s1_vld_d = s1_vld_q;
    if (bus.flush)
      s1_vld_d = 1'b0;
    else if (!stall)
      s1_vld_d = accept;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_vld_q <= 1'b0;
      op1_q    <= MUL_OP_MUL;
      tag1_q   <= '0;
      a1_q     <= '0;
      b1_q     <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      if (accept) begin
        op1_q  <= mult_op_e'(bus.in_op);
        tag1_q <= bus.in_tag;
        a1_q   <= bus.in_src1;
        b1_q   <= bus.in_src2;
      end
    end
  end

  // Unsigned sum of the partials, then two's-complement fixups:
  // a negative signed operand contributed 2^DATA_W * other too much.
  always_comb begin
    mid   = PW'(plh) + PW'(phl);
    p_sum = PW'(pll) + (mid << HALF_W)
          + {phh, {DATA_W{1'b0}}};
    if (mult_a_signed(op1_q) && a1_q[DATA_W-1])
      p_sum = p_sum - {b1_q, {DATA_W{1'b0}}};
    if ((op1_q == MUL_OP_MULXSS) && b1_q[DATA_W-1])
      p_sum = p_sum - {a1_q, {DATA_W{1'b0}}};
    res2_d = DATA_W'(mult_select(
      (2*MULT_MAX_W)'(p_sum), DATA_W, op1_q));
  end

  always_comb begin
    s2_vld_d = s2_vld_q;
    if (bus.flush)
      s2_vld_d = 1'b0;
    else if (!stall)
      s2_vld_d = s1_vld_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_vld_q <= 1'b0;
      res2_q   <= '0;
      tag2_q   <= '0;
    end else begin
      s2_vld_q <= s2_vld_d;
      if (!stall && s1_vld_q) begin
        res2_q <= res2_d;
        tag2_q <= tag1_q;
      end
    end
  end

`ifdef NIOS_MULT_OUT_REG_EN
  logic              s3_vld_q, s3_vld_d;
  logic [DATA_W-1:0] res3_q;
  logic [TAG_W-1:0]  tag3_q;

  assign stall = s3_vld_q && !bus.out_ready;

  always_comb begin
    s3_vld_d = s3_vld_q;
    if (bus.flush)
      s3_vld_d = 1'b0;
    else if (!stall)
      s3_vld_d = s2_vld_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s3_vld_q <= 1'b0;
      res3_q   <= '0;
      tag3_q   <= '0;
    end else begin
      s3_vld_q <= s3_vld_d;
      if (!stall && s2_vld_q) begin
        res3_q <= res2_q;
        tag3_q <= tag2_q;
      end
    end
  end

  assign bus.out_valid  = s3_vld_q;
  assign bus.out_result = res3_q;
  assign bus.out_tag    = tag3_q;
`else
  assign stall = s2_vld_q && !bus.out_ready;

  assign bus.out_valid  = s2_vld_q;
  assign bus.out_result = res2_q;
  assign bus.out_tag    = tag2_q;
`endif

endmodule

// File: tb/tb_nios_mult_pipe.sv
// tb_nios_mult_pipe: directed vectors with queue scoreboard for nios_mult_pipe.
// Drives at negedge, checks shortly after; latency checks assume the 2-stage build.
module tb_nios_mult_pipe;
  import nios_mult_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          cyc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];

  nios_mult_if #(.DATA_W(32), .TAG_W(5)) bus ();

  nios_mult_pipe #(.DATA_W(32), .TAG_W(5)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    #2;
    if (reset_n) begin
      chk("in_ready", 64'(bus.in_ready),
          64'(!(bus.out_valid && !bus.out_ready)));
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_out: got %0h tag %0d expected none",
                   bus.out_result, bus.out_tag);
        end else begin
          e = q.pop_front();
          chk("result", 64'(bus.out_result), 64'(e.res));
          chk("tag", 64'(bus.out_tag), 64'(e.tag));
          if (e.lat)
            chk("latency", 64'(cyc - e.cyc), 64'd2);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] tag,
                       input logic [31:0] res,
                       input bit lat);
    bit acc = 1'b0;
    int n = 0;
    exp_t e;
    while (!acc) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_src1  = a;
      bus.in_src2  = b;
      bus.in_tag   = tag;
      #1;
      acc = bus.in_ready && !bus.flush && reset_n;
      if (acc) begin
        e.res = res;
        e.tag = tag;
        e.cyc = cyc;
        e.lat = lat;
        q.push_back(e);
      end
      n++;
      if (!acc && n > 50) begin
        n_vec++;
        n_err++;
        $display("FAIL issue_timeout: got no accept expected accept");
        break;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'd0;
    bus.in_src1   = '0;
    bus.in_src2   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_result", 64'(bus.out_result), 64'd0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    issue(MUL_OP_MUL, 32'h3, 32'h5, 5'd7, 32'hF, 1'b1);
    idle();
    drain();

    issue(MUL_OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h00000001, 1'b1);
    issue(MUL_OP_MULXUU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 1'b1);
    issue(MUL_OP_MULXSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 1'b1);
    issue(MUL_OP_MULXSS, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'h00000000, 1'b1);
    issue(MUL_OP_MULXSS, 32'h80000000, 32'h80000000, 5'd5, 32'h40000000, 1'b1);
    issue(MUL_OP_MULXSU, 32'h80000000, 32'h00000002, 5'd6, 32'hFFFFFFFF, 1'b1);
    idle();
    drain();

    fork
      begin
        issue(MUL_OP_MUL,    32'h00000010, 32'h00000010, 5'd10, 32'h00000100, 1'b0);
        issue(MUL_OP_MULXUU, 32'h80000000, 32'h00000004, 5'd11, 32'h00000002, 1'b0);
        issue(MUL_OP_MULXSS, 32'hFFFFFFFE, 32'h00000003, 5'd12, 32'hFFFFFFFF, 1'b0);
        issue(MUL_OP_MUL,    32'h12345678, 32'h00000010, 5'd13, 32'h23456780, 1'b0);
        issue(MUL_OP_MULXSU, 32'h7FFFFFFF, 32'h80000000, 5'd14, 32'h3FFFFFFF, 1'b0);
        issue(MUL_OP_MULXSS, 32'h7FFFFFFF, 32'h80000000, 5'd15, 32'hC0000000, 1'b0);
        issue(MUL_OP_MULXUU, 32'h00010000, 32'h00010000, 5'd16, 32'h00000001, 1'b0);
        issue(MUL_OP_MUL,    32'hFFFFFFFF, 32'h00000002, 5'd17, 32'hFFFFFFFE, 1'b0);
        idle();
      end
      begin
        repeat (4) @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    issue(MUL_OP_MUL, 32'h2, 32'h2, 5'd20, 32'h4, 1'b0);
    issue(MUL_OP_MUL, 32'h3, 32'h3, 5'd21, 32'h9, 1'b0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_op     = MUL_OP_MUL;
    bus.in_src1   = 32'h5;
    bus.in_src2   = 32'h5;
    bus.in_tag    = 5'd22;
    #1;
    q.delete();
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("flush_quiet", 64'(bus.out_valid), 64'd0);
    end
    issue(MUL_OP_MUL, 32'h6, 32'h7, 5'd23, 32'h2A, 1'b1);
    idle();
    drain();

    bus.out_ready = 1'b0;
    issue(MUL_OP_MUL, 32'h9, 32'h9, 5'd24, 32'h51, 1'b0);
    idle();
    @(negedge clk);
    #1;
    chk("stalled_valid", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_out_result", 64'(bus.out_result), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;

    issue(MUL_OP_MULXUU, 32'hFFFFFFFF, 32'h00000002, 5'd25, 32'h00000001, 1'b1);
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
